// File: rtl/canny_tile_feeder.sv
// canny_tile_feeder: streams 20x20 pixel tiles from tile memory into the CHIP
// edge core at five pixels per beat, and packs the returned serial edge bits
// into 18-bit row words. It runs a sequence of tiles and pulses chip_reset
// before each one.
module canny_tile_feeder #(
  parameter int PIX_W    = 4,
  parameter int LANES    = 5,
  parameter int BEATS    = 80,
  parameter int OUT_W    = 18,
  parameter int OUT_ROWS = 18,
  parameter int ADDR_W   = 16,
  parameter int TILE_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [TILE_W-1:0]      tile_count,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf_err,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [LANES*PIX_W-1:0] mem_rdata,
  output logic                   chip_reset,
  output logic [PIX_W-1:0]       pixel_in0,
  output logic [PIX_W-1:0]       pixel_in1,
  output logic [PIX_W-1:0]       pixel_in2,
  output logic [PIX_W-1:0]       pixel_in3,
  output logic [PIX_W-1:0]       pixel_in4,
  output logic                   load_end,
  input  logic                   edge_out,
  input  logic                   readable,
  output logic                   row_valid,
  output logic [OUT_W-1:0]       row_data,
  output logic [4:0]             row_idx,
  output logic [TILE_W-1:0]      tile_idx
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int COL_W  = $clog2(OUT_W);

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_FEED, S_WAIT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [TILE_W-1:0]        cnt_q, cnt_d;
  logic [TILE_W-1:0]        tile_idx_q, tile_idx_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic                     mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [LANES*PIX_W-1:0]   pix_q, pix_d;
  logic                     load_end_q, load_end_d;
  logic                     chip_reset_q, chip_reset_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [4:0]               row_cnt_q, row_cnt_d;
  logic [OUT_W-1:0]         shreg_q, shreg_d;
  logic                     row_valid_q, row_valid_d;
  logic [OUT_W-1:0]         row_data_q, row_data_d;
  logic [4:0]               row_idx_q, row_idx_d;
  logic                     tile_full;
  logic [TILE_W:0]          tile_next;

  assign tile_full = (row_cnt_q == 5'(OUT_ROWS));
  assign tile_next = {1'b0, tile_idx_q} + (TILE_W+1)'(1);

  // Next-state logic: edge-bit collection first, then the sequencing FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tile_idx_d   = tile_idx_q;
    beat_d       = beat_q;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    pix_d        = pix_q;
    load_end_d   = load_end_q;
    chip_reset_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    col_d        = col_q;
    row_cnt_d    = row_cnt_q;
    shreg_d      = shreg_q;
    row_valid_d  = 1'b0;
    row_data_d   = row_data_q;
    row_idx_d    = row_idx_q;

    if (readable) begin
      if ((state_q == S_FEED || state_q == S_WAIT) && !tile_full) begin
        shreg_d[col_q] = edge_out;
        if (col_q == COL_W'(OUT_W-1)) begin
          row_valid_d = 1'b1;
          row_data_d  = shreg_d;
          row_idx_d   = row_cnt_q;
          col_d       = '0;
          row_cnt_d   = row_cnt_q + 5'd1;
          if (row_cnt_q == 5'(OUT_ROWS-1)) begin
            load_end_d = 1'b0;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (tile_count != '0) begin
            state_d      = S_CRST;
            cnt_d        = tile_count;
            tile_idx_d   = '0;
            busy_d       = 1'b1;
            chip_reset_d = 1'b1;
            mem_rd_en_d  = 1'b1;
            mem_addr_d   = '0;
            beat_d       = '0;
            col_d        = '0;
            row_cnt_d    = '0;
            load_end_d   = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_CRST: begin
        state_d     = S_FEED;
        mem_rd_en_d = 1'b1;
        mem_addr_d  = mem_addr_q + ADDR_W'(1);
        beat_d      = '0;
      end
      S_FEED: begin
        // Read data trails mem_rd_en by one cycle, so the final beat is captured
        // one cycle after the last read was issued.
        pix_d = mem_rdata;
        if (beat_q == BEAT_W'(BEATS-1)) begin
          load_end_d = 1'b1;
          state_d    = S_WAIT;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
        if (beat_q < BEAT_W'(BEATS-2)) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
        end
      end
      S_WAIT: begin
        // Advance one cycle after the last bit so the final row pulse still
        // carries this tile's index; tiles are contiguous, so the next base
        // address is simply the last address plus one.
        if (tile_full) begin
          load_end_d = 1'b0;
          tile_idx_d = tile_next[TILE_W-1:0];
          if (tile_next < {1'b0, cnt_q}) begin
            state_d      = S_CRST;
            chip_reset_d = 1'b1;
            mem_rd_en_d  = 1'b1;
            mem_addr_d   = mem_addr_q + ADDR_W'(1);
            col_d        = '0;
            row_cnt_d    = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tile_idx_q   <= '0;
      beat_q       <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      pix_q        <= '0;
      load_end_q   <= 1'b0;
      chip_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      col_q        <= '0;
      row_cnt_q    <= '0;
      shreg_q      <= '0;
      row_valid_q  <= 1'b0;
      row_data_q   <= '0;
      row_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tile_idx_q   <= tile_idx_d;
      beat_q       <= beat_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      pix_q        <= pix_d;
      load_end_q   <= load_end_d;
      chip_reset_q <= chip_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      col_q        <= col_d;
      row_cnt_q    <= row_cnt_d;
      shreg_q      <= shreg_d;
      row_valid_q  <= row_valid_d;
      row_data_q   <= row_data_d;
      row_idx_q    <= row_idx_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf_err    = ovf_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign chip_reset = chip_reset_q;
  assign load_end   = load_end_q;
  assign row_valid  = row_valid_q;
  assign row_data   = row_data_q;
  assign row_idx    = row_idx_q;
  assign tile_idx   = tile_idx_q;
  assign pixel_in0  = pix_q[0*PIX_W +: PIX_W];
  assign pixel_in1  = pix_q[1*PIX_W +: PIX_W];
  assign pixel_in2  = pix_q[2*PIX_W +: PIX_W];
  assign pixel_in3  = pix_q[3*PIX_W +: PIX_W];
  assign pixel_in4  = pix_q[4*PIX_W +: PIX_W];

endmodule

// File: tb/tb_canny_tile_feeder.sv
// Self-checking bench for canny_tile_feeder: tile memory model, CHIP model
// returning column-parity edge bits, an event monitor, and a scenario table.
module tb_canny_tile_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  tile_count = '0;
  logic        busy, done, ovf_err, mem_rd_en;
  logic [15:0] mem_addr;
  logic [19:0] mem_rdata = '0;
  logic        chip_reset;
  logic [3:0]  pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4;
  logic        load_end;
  logic        edge_out = 1'b0;
  logic        readable = 1'b0;
  logic        row_valid;
  logic [17:0] row_data;
  logic [4:0]  row_idx;
  logic [7:0]  tile_idx;

  int checks = 0;
  int errors = 0;

  canny_tile_feeder #(.PIX_W(4), .LANES(5), .BEATS(80), .OUT_W(18), .OUT_ROWS(18),
                      .ADDR_W(16), .TILE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .tile_count(tile_count),
    .busy(busy), .done(done), .ovf_err(ovf_err), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .chip_reset(chip_reset),
    .pixel_in0(pixel_in0), .pixel_in1(pixel_in1), .pixel_in2(pixel_in2),
    .pixel_in3(pixel_in3), .pixel_in4(pixel_in4), .load_end(load_end),
    .edge_out(edge_out), .readable(readable), .row_valid(row_valid),
    .row_data(row_data), .row_idx(row_idx), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  // Tile memory: word a holds five copies of a[3:0]; data one cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= {5{mem_addr[3:0]}};
    else           mem_rdata <= 20'($urandom);
  end

  // CHIP model: mode 1 sends every cycle while load_end is high (and past 324
  // bits regardless), mode 2 sends every other cycle from mid-feed.
  int chip_mode = 0;
  int chip_limit = 0;
  int chip_sent = 0;
  int chip_cyc = 0;
  bit force_rd = 1'b0;
  always @(posedge clk) begin
    bit go;
    #1;
    if (chip_reset) begin
      chip_sent = 0;
      chip_cyc  = 0;
    end else begin
      chip_cyc++;
    end
    go = 1'b0;
    if (chip_sent < chip_limit) begin
      if (chip_mode == 1 && (load_end || chip_sent >= 324)) go = 1'b1;
      if (chip_mode == 2 && chip_cyc >= 41 && ((chip_cyc - 41) % 2 == 0)) go = 1'b1;
    end
    edge_out = 1'b0;
    if (go) begin
      edge_out = ((chip_sent % 18) % 2) == 1;
      chip_sent++;
    end
    readable = go | force_rd;
  end

  // Monitor: tallies events and local violations; the main block compares them
  bit mon_clear = 1'b0;
  int crst_cnt, crst_double, rd_cnt, addr_bad, rows, row_bad, idx_bad;
  int done_cnt, done_bad, busy_cyc, lend_cyc, lane_bad, pix_bad, hold_bad;
  logic [15:0] exp_addr;
  logic        prev_crst = 1'b0;
  logic        prev_lend = 1'b0;
  logic [3:0]  prev_pix = '0;
  logic [19:0] prev_all = '0;
  always @(negedge clk) begin
    logic [19:0] all_pix;
    logic [3:0]  nxt;
    all_pix = {pixel_in4, pixel_in3, pixel_in2, pixel_in1, pixel_in0};
    nxt = prev_pix + 4'd1;
    if (mon_clear) begin
      crst_cnt = 0; crst_double = 0; rd_cnt = 0; addr_bad = 0; rows = 0;
      row_bad = 0; idx_bad = 0; done_cnt = 0; done_bad = 0; busy_cyc = 0;
      lend_cyc = 0; lane_bad = 0; pix_bad = 0; hold_bad = 0; exp_addr = '0;
    end else begin
      if (chip_reset) begin
        crst_cnt++;
        if (prev_crst) crst_double++;
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (mem_addr != exp_addr) addr_bad++;
        exp_addr = exp_addr + 16'd1;
      end
      if (row_valid) begin
        if (row_data != 18'h2AAAA) row_bad++;
        if (row_idx != 5'(rows % 18) || tile_idx != 8'(rows / 18)) idx_bad++;
        rows++;
      end
      if (done) begin
        done_cnt++;
        if (busy) done_bad++;
      end
      if (busy) busy_cyc++;
      if (load_end) lend_cyc++;
      if (load_end && !prev_lend && all_pix != {5{4'hF}}) lane_bad++;
      if (pixel_in0 != prev_pix && pixel_in0 != nxt) pix_bad++;
      if (load_end && prev_lend && all_pix != prev_all) hold_bad++;
    end
    prev_crst = chip_reset;
    prev_lend = load_end;
    prev_pix  = pixel_in0;
    prev_all  = all_pix;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ovf"}, int'(ovf_err), 0);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_chip_reset"}, int'(chip_reset), 0);
    chk({tag, "_load_end"}, int'(load_end), 0);
    chk({tag, "_row_valid"}, int'(row_valid), 0);
    chk({tag, "_row_data"}, int'(row_data), 0);
    chk({tag, "_row_idx"}, int'(row_idx), 0);
    chk({tag, "_tile_idx"}, int'(tile_idx), 0);
    chk({tag, "_pixels"}, int'({pixel_in4, pixel_in3, pixel_in2, pixel_in1, pixel_in0}), 0);
  endtask

  task automatic clear_mon();
    mon_clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_clear = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int tiles;
    int mode;
    int limit;
    int rd_idle;
    int exp_rows;
    int exp_crst;
    int exp_rd;
    int exp_ovf;
    int exp_lend;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    bit seen;
    clear_mon();
    chip_mode  = v.mode;
    chip_limit = v.limit;
    start      = 1'b1;
    tile_count = 8'(v.tiles);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy), 1);
    chk({tag, "_chip_reset_first"}, int'(chip_reset), 1);
    chk({tag, "_ovf_cleared"}, int'(ovf_err), 0);
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    repeat (3) @(negedge clk);
    if (v.rd_idle != 0) begin
      force_rd = 1'b1;
      @(negedge clk);
      force_rd = 1'b0;
      repeat (3) @(negedge clk);
    end
    chip_mode = 0;
    chk({tag, "_rows"}, rows, v.exp_rows);
    chk({tag, "_row_data_bad"}, row_bad, 0);
    chk({tag, "_row_tile_idx_bad"}, idx_bad, 0);
    chk({tag, "_chip_reset_pulses"}, crst_cnt, v.exp_crst);
    chk({tag, "_chip_reset_long"}, crst_double, 0);
    chk({tag, "_reads"}, rd_cnt, v.exp_rd);
    chk({tag, "_addr_bad"}, addr_bad, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, done_bad, 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_ovf"}, int'(ovf_err), v.exp_ovf);
    chk({tag, "_load_end_cycles"}, lend_cyc, v.exp_lend);
    chk({tag, "_beat79_lanes_bad"}, lane_bad, 0);
    chk({tag, "_pixel_seq_bad"}, pix_bad, 0);
    chk({tag, "_pixel_hold_bad"}, hold_bad, 0);
  endtask

  vec_t vecs[5];

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    vecs[0] = '{tiles:1, mode:1, limit:324, rd_idle:0, exp_rows:18, exp_crst:1, exp_rd:80,  exp_ovf:0, exp_lend:324};
    vecs[1] = '{tiles:3, mode:1, limit:324, rd_idle:0, exp_rows:54, exp_crst:3, exp_rd:240, exp_ovf:0, exp_lend:972};
    vecs[2] = '{tiles:1, mode:2, limit:324, rd_idle:0, exp_rows:18, exp_crst:1, exp_rd:80,  exp_ovf:0, exp_lend:607};
    vecs[3] = '{tiles:1, mode:1, limit:325, rd_idle:1, exp_rows:18, exp_crst:1, exp_rd:80,  exp_ovf:1, exp_lend:324};
    vecs[4] = '{tiles:2, mode:2, limit:324, rd_idle:0, exp_rows:36, exp_crst:2, exp_rd:160, exp_ovf:0, exp_lend:1214};

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in WAIT after 100 bits, then a clean single-tile run
    clear_mon();
    chip_mode  = 1;
    chip_limit = 100;
    start      = 1'b1;
    tile_count = 8'd1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(negedge clk);
      if (chip_sent >= 100) hit = 1'b1;
    end
    chk("midrst_bits_reached", int'(hit), 1);
    repeat (3) @(negedge clk);
    chk("midrst_load_end_held", int'(load_end), 1);
    chk("midrst_rows_before", rows, 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero_outputs("midrst");
    reset = 1'b0;
    chip_mode = 0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_busy_low", int'(busy), 0);
    run_vec(vecs[0], "after_rst");

    // tile_count of zero: immediate done, no activity
    clear_mon();
    start      = 1'b1;
    tile_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_pulse", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("zero_done_count", done_cnt, 1);
    chk("zero_reads", rd_cnt, 0);
    chk("zero_chip_reset", crst_cnt, 0);
    chk("zero_busy_cycles", busy_cyc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
